// File: rtl/saph_fpu_pkg.sv
// saph_fpu_pkg
// Shared types for the shader-core FPU issue path: the 32-bit float
// container, the operation mode encoding, request records and the issue
// stage state encoding.
package saph_fpu_pkg;

    localparam int SAPH_FPU_TAG_W = 5;

    typedef logic [31:0] float;

    typedef enum logic [1:0] {
        FPU_ADD  = 2'd0,
        FPU_MUL  = 2'd1,
        FPU_DIV  = 2'd2,
        FPU_SQRT = 2'd3
    } saph_fpu_mode_t;

    // Full core request as seen on the request port
    typedef struct packed {
        float                      lhs;
        float                      rhs;
        saph_fpu_mode_t            mode;
        logic [SAPH_FPU_TAG_W-1:0] tag;
    } saph_fpu_req_t;

    // Operand part of a request, stored next to a tag of configurable width
    typedef struct packed {
        float           lhs;
        float           rhs;
        saph_fpu_mode_t mode;
    } saph_fpu_op_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        RETIRE_ERR = 2'd2
    } saph_fpu_issue_state_t;

endpackage

// File: rtl/saph_fpi.sv
// saph_fpi
// Handshake between a GPU-side requester and the FPU demultiplexer.
// The FPU answers a triggered-and-ready operation exactly `latency`
// cycles later on q_res; has_modes advertises which modes are implemented.
interface saph_fpi #(
    parameter int latency = 2
) ();
    import saph_fpu_pkg::*;

    logic           d_trig;
    float           d_lhs;
    float           d_rhs;
    saph_fpu_mode_t d_mode;
    logic           d_ready;
    logic [3:0]     has_modes;
    float           q_res;

    modport GPU (
        output d_trig, d_lhs, d_rhs, d_mode,
        input  d_ready, has_modes, q_res
    );

    modport FPU (
        input  d_trig, d_lhs, d_rhs, d_mode,
        output d_ready, has_modes, q_res
    );

endinterface

// File: rtl/saph_fpu_issue_fifo.sv
// saph_fpu_issue_fifo
// Generic synchronous FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart without a separate flag. ready_o is registered and
// reflects occupancy after the current cycle's push/pop, so a full FIFO
// never admits a push in the same cycle as a pop.
module saph_fpu_issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PtrW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             ready_o,
    output logic [PtrW-1:0]  count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wrPtr_q, wrPtr_d;
    logic [PtrW-1:0]  rdPtr_q, rdPtr_d;
    logic [PtrW-1:0]  countNext;
    logic             ready_q;
    logic             doPush, doPop;

    assign count_o = wrPtr_q - rdPtr_q;
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[PtrW-1] != rdPtr_q[PtrW-1]) &&
                     (wrPtr_q[PtrW-2:0] == rdPtr_q[PtrW-2:0]);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign rdata_o = mem_q[rdPtr_q[PtrW-2:0]];
    assign ready_o = ready_q;

    // Advance pointers by the accepted push/pop of this cycle
    always_comb begin
        wrPtr_d   = wrPtr_q + PtrW'(doPush);
        rdPtr_d   = rdPtr_q + PtrW'(doPop);
        countNext = wrPtr_d - rdPtr_d;
    end

    // Pointer and ready registers; ready looks at next-cycle occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            ready_q <= 1'b1;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            ready_q <= (countNext < PtrW'(DEPTH));
        end
    end

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q[PtrW-2:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/saph_fpu_issue.sv
// saph_fpu_issue
// In-order issue stage from the shader core's FP request port to the
// saph_fpi GPU port. Requests queue in a FIFO; the head drives d_* and
// is popped on d_trig && d_ready. Accepted tags walk a shadow pipeline
// as deep as the FPU latency so results come back tagged and in order.
// Heads whose mode no FPU implements are retired locally with res_err
// once everything older has left the pipeline.
// Optional: define SAPH_FPU_ISSUE_BYPASS_EN to let a supported request
// skip the empty FIFO and reach d_* combinationally in its push cycle.
module saph_fpu_issue
    import saph_fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = SAPH_FPU_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  float             req_lhs,
    input  float             req_rhs,
    input  logic [1:0]       req_mode,
    input  logic [TAG_W-1:0] req_tag,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output float             res_value,
    output logic             res_err,
    output logic             busy,
    saph_fpi.GPU             fpi
);

    localparam int Lat    = fpi.latency;
    localparam int EntryW = $bits(saph_fpu_op_t) + TAG_W;
    localparam int CntW   = $clog2(DEPTH) + 1;

    logic                  fifoPush, fifoPop;
    logic                  fifoEmpty, fifoFull, fifoReady;
    logic [EntryW-1:0]     fifoWdata, fifoRdata;
    logic [CntW-1:0]       fifoCount;
    saph_fpu_op_t          reqOp, headOp;
    logic [TAG_W-1:0]      headTag;
    logic                  headSupported;
    saph_fpu_issue_state_t state;
    logic                  accept, bypass, retire;
    logic [TAG_W-1:0]      acceptTag;
    logic                  pipeEmpty, outValid;
    logic [TAG_W-1:0]      outTag;

    assign reqOp     = '{lhs: req_lhs, rhs: req_rhs, mode: saph_fpu_mode_t'(req_mode)};
    assign fifoWdata = {req_tag, reqOp};
    assign {headTag, headOp} = fifoRdata;

    assign req_ready = fifoReady;
    assign fifoPush  = req_valid && req_ready && !fifoFull && !bypass;
    assign fifoPop   = (accept && (state == ISSUE)) || retire;

    saph_fpu_issue_fifo #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifoPush),
        .wdata_i (fifoWdata),
        .pop_i   (fifoPop),
        .rdata_o (fifoRdata),
        .empty_o (fifoEmpty),
        .full_o  (fifoFull),
        .ready_o (fifoReady),
        .count_o (fifoCount)
    );

    assign headSupported = fpi.has_modes[headOp.mode];

    // State is a pure function of the current head; has_modes may change any cycle
    always_comb begin
        state = IDLE;
        if (!fifoEmpty) begin
            state = headSupported ? ISSUE : RETIRE_ERR;
        end
    end

    // Drive the FPU port from the head, or from the request itself when bypassing
    always_comb begin
        bypass     = 1'b0;
        fpi.d_trig = (state == ISSUE);
        fpi.d_lhs  = headOp.lhs;
        fpi.d_rhs  = headOp.rhs;
        fpi.d_mode = headOp.mode;
        acceptTag  = headTag;
`ifdef SAPH_FPU_ISSUE_BYPASS_EN
        // Errors never enter the tag pipeline, so an empty FIFO means nothing older can be pending
        if ((state == IDLE) && req_valid && req_ready && fpi.has_modes[req_mode]) begin
            fpi.d_trig = 1'b1;
            fpi.d_lhs  = req_lhs;
            fpi.d_rhs  = req_rhs;
            fpi.d_mode = saph_fpu_mode_t'(req_mode);
            acceptTag  = req_tag;
            bypass     = fpi.d_ready;
        end
`endif
        accept = fpi.d_trig && fpi.d_ready;
    end

    // An unsupported head retires only when no older result can still appear
    assign retire = (state == RETIRE_ERR) && pipeEmpty;

    if (Lat > 0) begin : g_pipe
        logic [Lat-1:0]   stValid_q;
        logic [TAG_W-1:0] stTag_q [Lat];

        // Shift each accepted tag one stage per cycle toward the result port
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                stValid_q <= '0;
                for (int i = 0; i < Lat; i++) begin
                    stTag_q[i] <= '0;
                end
            end else begin
                stValid_q[0] <= accept;
                stTag_q[0]   <= acceptTag;
                for (int i = 1; i < Lat; i++) begin
                    stValid_q[i] <= stValid_q[i-1];
                    stTag_q[i]   <= stTag_q[i-1];
                end
            end
        end

        assign outValid  = stValid_q[Lat-1];
        assign outTag    = stTag_q[Lat-1];
        assign pipeEmpty = ~|stValid_q;
    end else begin : g_nopipe
        assign outValid  = accept;
        assign outTag    = acceptTag;
        assign pipeEmpty = 1'b1;
    end

    // Result port: FPU result at the output stage, else a local error retirement
    always_comb begin
        res_valid = 1'b0;
        res_tag   = '0;
        res_value = '0;
        res_err   = 1'b0;
        if (outValid) begin
            res_valid = 1'b1;
            res_tag   = outTag;
            res_value = fpi.q_res;
        end else if (retire) begin
            res_valid = 1'b1;
            res_tag   = headTag;
            res_err   = 1'b1;
        end
    end

    assign busy = (fifoCount != '0) || !pipeEmpty;

endmodule

// File: tb/tb_saph_fpu_issue.sv
// tb_saph_fpu_issue
// Directed vectors for saph_fpu_issue with a two-cycle-latency FPU stand-in.
// The stand-in returns lhs ^ rhs ^ 0x3FC00000 ^ mode, so 1.0 + 2.0 maps to 3.0.
module tb_saph_fpu_issue;
    import saph_fpu_pkg::*;

    typedef struct {
        logic          v;
        saph_fpu_req_t req;
        logic          dr;
        logic [3:0]    has;
        logic          eRdy;
        logic          eTrig;
        logic          eResV;
        logic [4:0]    eTag;
        float          eVal;
        logic          eErr;
        logic          eBusy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       reqValid;
    logic       reqReady;
    float       reqLhs, reqRhs;
    logic [1:0] reqMode;
    logic [4:0] reqTag;
    logic       resValid;
    logic [4:0] resTag;
    float       resValue;
    logic       resErr;
    logic       busy;

    int vecCount  = 0;
    int missCount = 0;
    int acceptSeen;

    vec_t       vecs[$];
    logic [4:0] gotTag[$];
    float       gotVal[$];
    logic       gotErr[$];

    float fpuStage [2];

    saph_fpi #(.latency(2)) fpi ();

    saph_fpu_issue #(.DEPTH(4), .TAG_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (reqValid),
        .req_ready (reqReady),
        .req_lhs   (reqLhs),
        .req_rhs   (reqRhs),
        .req_mode  (reqMode),
        .req_tag   (reqTag),
        .res_valid (resValid),
        .res_tag   (resTag),
        .res_value (resValue),
        .res_err   (resErr),
        .busy      (busy),
        .fpi       (fpi)
    );

    always #5 clk = ~clk;

    function automatic float fpuFunc(input float l, input float r, input logic [1:0] m);
        return l ^ r ^ 32'h3FC0_0000 ^ {30'd0, m};
    endfunction

    // FPU stand-in: fixed two-cycle latency, poison value when nothing was accepted
    always @(posedge clk) begin
        fpuStage[1] <= fpuStage[0];
        fpuStage[0] <= (fpi.d_trig && fpi.d_ready) ?
                       fpuFunc(fpi.d_lhs, fpi.d_rhs, fpi.d_mode) : 32'hDEAD_BEEF;
    end
    assign fpi.q_res = fpuStage[1];

    task automatic applyStimulus(input logic v, input float l, input float r,
                                 input logic [1:0] m, input logic [4:0] t,
                                 input logic dr, input logic [3:0] has);
        @(negedge clk);
        reqValid      = v;
        reqLhs        = l;
        reqRhs        = r;
        reqMode       = m;
        reqTag        = t;
        fpi.d_ready   = dr;
        fpi.has_modes = has;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic v, input float l, input float r, input logic [1:0] m,
                          input logic [4:0] t, input logic dr, input logic [3:0] has,
                          input logic eRdy, input logic eTrig, input logic eResV,
                          input logic [4:0] eTag, input float eVal, input logic eErr,
                          input logic eBusy);
        vec_t x;
        x.v        = v;
        x.req.lhs  = l;
        x.req.rhs  = r;
        x.req.mode = saph_fpu_mode_t'(m);
        x.req.tag  = t;
        x.dr       = dr;
        x.has      = has;
        x.eRdy     = eRdy;
        x.eTrig    = eTrig;
        x.eResV    = eResV;
        x.eTag     = eTag;
        x.eVal     = eVal;
        x.eErr     = eErr;
        x.eBusy    = eBusy;
        vecs.push_back(x);
    endtask

    task automatic collectResult();
        if (fpi.d_trig && fpi.d_ready) acceptSeen++;
        if (resValid) begin
            gotTag.push_back(resTag);
            gotVal.push_back(resValue);
            gotErr.push_back(resErr);
        end
    endtask

    task automatic clearResults();
        gotTag.delete();
        gotVal.delete();
        gotErr.delete();
        acceptSeen = 0;
    endtask

    task automatic checkResetState(input string tagName);
        checkOutput({tagName, " req_ready"}, 32'(reqReady), 32'd1);
        checkOutput({tagName, " res_valid"}, 32'(resValid), 32'd0);
        checkOutput({tagName, " res_tag"}, 32'(resTag), 32'd0);
        checkOutput({tagName, " res_value"}, resValue, 32'd0);
        checkOutput({tagName, " res_err"}, 32'(resErr), 32'd0);
        checkOutput({tagName, " d_trig"}, 32'(fpi.d_trig), 32'd0);
        checkOutput({tagName, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        float l, r;

        rst_n         = 1'b0;
        reqValid      = 1'b0;
        reqLhs        = '0;
        reqRhs        = '0;
        reqMode       = '0;
        reqTag        = '0;
        fpi.d_ready   = 1'b0;
        fpi.has_modes = 4'b0001;
        acceptSeen    = 0;

        // Single op: 1.0 + 2.0 -> 3.0, result three cycles after the push
        addVec(1, 32'h3F80_0000, 32'h4000_0000, 0, 3, 1, 4'b0101, 1, 0, 0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 1, 4'b0101, 1, 1, 0, 0, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 1, 4'b0101, 1, 0, 0, 0, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 1, 4'b0101, 1, 0, 1, 3, 32'h4040_0000, 0, 1);
        addVec(0, 0, 0, 0, 0, 1, 4'b0101, 1, 0, 0, 0, 0, 0, 0);

        // Back-to-back tags 1..4 with d_ready held high
        for (int i = 1; i <= 4; i++) begin
            addVec(1, 32'h4100_0000 | i, 32'h0001_0000 << i, 0, 5'(i), 1, 4'b0001,
                   1, (i > 1), (i == 4), 5'(i - 3), (i == 4) ? fpuFunc(32'h4100_0001, 32'h0002_0000, 0) : 0,
                   0, (i > 1));
        end
        for (int i = 2; i <= 4; i++) begin
            addVec(0, 0, 0, 0, 0, 1, 4'b0001, 1, (i == 2), 1, 5'(i),
                   fpuFunc(32'h4100_0000 | i, 32'h0001_0000 << i, 0), 0, 1);
        end
        addVec(0, 0, 0, 0, 0, 1, 4'b0001, 1, 0, 0, 0, 0, 0, 0);

        // Unsupported mode 2 behind a supported op: error only after tag 7
        addVec(1, 32'h1111_1111, 32'h2222_2222, 0, 7, 1, 4'b0001, 1, 0, 0, 0, 0, 0, 0);
        addVec(1, 32'h3333_3333, 32'h4444_4444, 2, 8, 1, 4'b0001, 1, 1, 0, 0, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 1, 4'b0001, 1, 0, 0, 0, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 1, 4'b0001, 1, 0, 1, 7, fpuFunc(32'h1111_1111, 32'h2222_2222, 0), 0, 1);
        addVec(0, 0, 0, 0, 0, 1, 4'b0001, 1, 0, 1, 8, 0, 1, 1);
        addVec(0, 0, 0, 0, 0, 1, 4'b0001, 1, 0, 0, 0, 0, 0, 0);

        // Unsupported head with an empty pipeline retires on the next cycle
        addVec(1, 32'h5555_5555, 32'h6666_6666, 3, 9, 1, 4'b0001, 1, 0, 0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 1, 4'b0001, 1, 0, 1, 9, 0, 1, 1);
        addVec(0, 0, 0, 0, 0, 1, 4'b0001, 1, 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkResetState("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].v, vecs[i].req.lhs, vecs[i].req.rhs, vecs[i].req.mode,
                          vecs[i].req.tag, vecs[i].dr, vecs[i].has);
            checkOutput($sformatf("v%0d req_ready", i), 32'(reqReady), 32'(vecs[i].eRdy));
            checkOutput($sformatf("v%0d d_trig", i), 32'(fpi.d_trig), 32'(vecs[i].eTrig));
            checkOutput($sformatf("v%0d res_valid", i), 32'(resValid), 32'(vecs[i].eResV));
            checkOutput($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].eBusy));
            if (vecs[i].eResV) begin
                checkOutput($sformatf("v%0d res_tag", i), 32'(resTag), 32'(vecs[i].eTag));
                checkOutput($sformatf("v%0d res_value", i), resValue, vecs[i].eVal);
                checkOutput($sformatf("v%0d res_err", i), 32'(resErr), 32'(vecs[i].eErr));
            end
        end

        // Full FIFO: four pushes fill it, the fifth waits until one cycle after the first pop
        clearResults();
        for (int t = 10; t <= 13; t++) begin
            applyStimulus(1, 32'h40A0_0000 + t, 32'h3E00_0000 + t, 0, 5'(t), 0, 4'b0001);
            checkOutput($sformatf("full push%0d req_ready", t), 32'(reqReady), 32'd1);
        end
        applyStimulus(1, 32'h40A0_0000 + 14, 32'h3E00_0000 + 14, 0, 5'd14, 0, 4'b0001);
        checkOutput("full req_ready low", 32'(reqReady), 32'd0);
        checkOutput("full d_trig held", 32'(fpi.d_trig), 32'd1);
        applyStimulus(1, 32'h40A0_0000 + 14, 32'h3E00_0000 + 14, 0, 5'd14, 1, 4'b0001);
        checkOutput("full pop cycle req_ready", 32'(reqReady), 32'd0);
        collectResult();
        applyStimulus(1, 32'h40A0_0000 + 14, 32'h3E00_0000 + 14, 0, 5'd14, 1, 4'b0001);
        checkOutput("full after pop req_ready", 32'(reqReady), 32'd1);
        collectResult();
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 4'b0001);
            collectResult();
        end
        checkOutput("full result count", 32'(gotTag.size()), 32'd5);
        for (int k = 0; k < 5 && k < gotTag.size(); k++) begin
            checkOutput($sformatf("full res%0d tag", k), 32'(gotTag[k]), 32'(10 + k));
            checkOutput($sformatf("full res%0d value", k), gotVal[k],
                        fpuFunc(32'h40A0_0000 + 10 + k, 32'h3E00_0000 + 10 + k, 0));
            checkOutput($sformatf("full res%0d err", k), 32'(gotErr[k]), 32'd0);
        end
        checkOutput("full busy idle", 32'(busy), 32'd0);

        // Stall: d_ready pattern 1,0,0,1 keeps d_* steady on the waiting head
        clearResults();
        applyStimulus(1, 32'h4010_0020, 32'h3F10_0020, 0, 5'd20, 0, 4'b0001);
        collectResult();
        applyStimulus(1, 32'h4010_0021, 32'h3F10_0021, 0, 5'd21, 0, 4'b0001);
        checkOutput("stall head20 d_lhs", fpi.d_lhs, 32'h4010_0020);
        checkOutput("stall head20 d_trig", 32'(fpi.d_trig), 32'd1);
        collectResult();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 0, 0, 0, 0, (c == 0 || c == 3), 4'b0001);
            l = (c == 0) ? 32'h4010_0020 : 32'h4010_0021;
            r = (c == 0) ? 32'h3F10_0020 : 32'h3F10_0021;
            checkOutput($sformatf("stall c%0d d_trig", c), 32'(fpi.d_trig), 32'd1);
            checkOutput($sformatf("stall c%0d d_lhs", c), fpi.d_lhs, l);
            checkOutput($sformatf("stall c%0d d_rhs", c), fpi.d_rhs, r);
            checkOutput($sformatf("stall c%0d d_mode", c), 32'(fpi.d_mode), 32'd0);
            collectResult();
        end
        for (int c = 0; c < 6; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 4'b0001);
            collectResult();
        end
        checkOutput("stall accept count", 32'(acceptSeen), 32'd2);
        checkOutput("stall result count", 32'(gotTag.size()), 32'd2);
        for (int k = 0; k < 2 && k < gotTag.size(); k++) begin
            checkOutput($sformatf("stall res%0d tag", k), 32'(gotTag[k]), 32'(20 + k));
            checkOutput($sformatf("stall res%0d value", k), gotVal[k],
                        fpuFunc(32'h4010_0020 + k, 32'h3F10_0020 + k, 0));
        end

        // Reset mid-flight: two ops inside the tag pipeline are discarded
        applyStimulus(1, 32'h0000_0025, 32'h0000_0052, 0, 5'd25, 1, 4'b0001);
        applyStimulus(1, 32'h0000_0026, 32'h0000_0062, 0, 5'd26, 1, 4'b0001);
        applyStimulus(0, 0, 0, 0, 0, 1, 4'b0001);
        checkOutput("midreset in flight busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkResetState("midreset");
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 4'b0001);
            checkOutput($sformatf("midreset c%0d res_valid", c), 32'(resValid), 32'd0);
            checkOutput($sformatf("midreset c%0d busy", c), 32'(busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/saph_fpu_issue.md
# saph_fpu_issue

Buffered in-order issue stage between a shader core's floating-point request port and the FPU demultiplexer's GPU-side `saph_fpi` port. It queues core requests in a small FIFO and drives one operation per cycle into the `saph_fpi` handshake. It tracks each accepted operation's destination tag through a fixed-latency shadow pipeline and returns results to the core, tagged and in issue order. Modes that no attached FPU implements are retired locally with an error flag and are never issued.

## Interface
Parameters:
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `TAG_W`, 5: destination tag width.
- FPU latency is taken from `fpi.latency`, not from a parameter.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  core request valid.
- `req_ready`  out  1  FIFO can accept.
- `req_lhs`  in  `float`  left operand.
- `req_rhs`  in  `float`  right operand.
- `req_mode`  in  2  operation mode; indexes `has_modes`.
- `req_tag`  in  `TAG_W`  destination tag.
- `res_valid`  out  1  result valid for one cycle; no backpressure.
- `res_tag`  out  `TAG_W`  tag of the result.
- `res_value`  out  `float`  result value; 0 when `res_err`.
- `res_err`  out  1  mode unsupported, operation not executed.
- `busy`  out  1  FIFO non-empty or any operation in flight.
- `fpi`  `saph_fpi.GPU` modport  drives `d_trig`, `d_lhs`, `d_rhs`, `d_mode`; reads `d_ready`, `has_modes`, `q_res`.

## Operation
- Push: `req_valid && req_ready`. `req_ready = (count < DEPTH)`, registered state only. When full, a simultaneous pop does not admit a push in the same cycle.
- Head supported when `fpi.has_modes[head.mode]`.
- `fpi.d_trig = head_valid && supported`.
- `d_lhs`, `d_rhs`, `d_mode` come from the head entry.
- Accept: `d_trig && fpi.d_ready`. An accept pops the head and enters `{1, head.tag}` into the tag pipeline.
- Tag pipeline: `latency` register stages.
  - At the output stage, `res_valid = 1`, `res_tag = stage.tag`, `res_value = fpi.q_res`, `res_err = 0`.
  - With `latency == 0`, the output is combinational in the accept cycle.
- Unsupported head (state RETIRE_ERR): wait until the tag pipeline is empty and no FPU result is due this cycle. Then pop and emit `res_valid=1`, `res_err=1`, `res_value=0`, `res_tag=head.tag`. This keeps results in issue order.
- States: IDLE (FIFO empty), ISSUE (supported head), RETIRE_ERR (unsupported head, draining). The state follows from the head entry each cycle.
- Pointers are `$clog2(DEPTH)+1` bits and wrap naturally. Full when the pointer MSBs differ and the low bits are equal.
- `has_modes` is re-evaluated every cycle against the current head.

## Timing
- Reset (`rst_n=0` at a clock edge): FIFO empty, tag pipeline cleared, `res_valid=0`, `res_tag=0`, `res_value=0`, `res_err=0`, `d_trig=0`, `busy=0`, `req_ready=1` from the first cycle after reset.
- Reset mid-operation discards queued and in-flight entries. FPU results arriving afterwards are ignored.
- Latency, without bypass: push at cycle T, earliest accept at T+1, `res_valid` at T+1+latency.
- Throughput: one accept per cycle while `d_ready` is held.
- A `d_ready` low leaves the head and `d_*` stable. `d_trig` stays high.
- Error retirement: one cycle after the pipeline drains. Minimum one cycle per entry.

## Configuration
- `SAPH_FPU_ISSUE_BYPASS_EN` defined: when the FIFO is empty and the pipeline holds no older error entry, a supported request drives `d_*` combinationally in its push cycle. If `d_ready` is high, it is accepted without being written to the FIFO, so result latency is T+latency. `req_ready` remains registered.
- Undefined: all requests pass through the FIFO. No combinational path from `req_*` to `fpi.d_*`.

## Structure
- In `saph_fpu_pkg`:
  - `float` typedef.
  - `saph_fpu_mode_t` 2-bit mode enum.
  - `saph_fpu_req_t` struct `{lhs, rhs, mode, tag}`, parameterised by `TAG_W` through a package constant.
- Sub-module `saph_fpu_issue_fifo`: generic synchronous FIFO with count, full/empty, and registered `ready`. The issue logic and tag pipeline stay in `saph_fpu_issue`.

## Test plan
- **Single op:** latency=2, mode 0 supported; push lhs=0x3F800000, rhs=0x40000000, tag=3 at T; FPU returns 0x40400000 → `res_valid` at T+3 with tag 3, value 0x40400000, err 0.
- **Back-to-back:** 4 pushes with tags 1..4 and `d_ready` held high → 4 consecutive `res_valid` cycles in tag order 1,2,3,4; `busy` falls the cycle after the last result.
- **Full:** `d_ready=0`, DEPTH=4; push 5 times → `req_ready=0` after the 4th push; raise `d_ready` → `req_ready=1` one cycle after the first pop; the 5th push is then accepted.
- **Unsupported mode:** has_modes=4'b0001; push mode 0 (tag 7) then mode 2 (tag 8) → tag 7 result with err=0, followed by tag 8 with err=1 and value 0, never before tag 7; `d_trig` is never asserted for mode 2.
- **Stall:** `d_ready` toggles 1,0,0,1 with the head fixed → `d_*` stable and `d_trig=1` throughout; exactly one accept per `d_ready=1` cycle.
- **Reset mid-flight:** 2 ops in flight, drop `rst_n` for one cycle → no `res_valid` afterwards, all outputs at reset values, `req_ready=1`.
